// File: rtl/demux_dispatch_pkg.sv
// Shared types and constants for the demux dispatch controller.
package demux_dispatch_pkg;

  // Holding-register occupancy.
  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  // Target selection modes.
  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  // Width of each per-channel dispatch counter.
  localparam int CNT_W = 16;

endpackage

// File: rtl/demux_dispatch_ctrl_rr_pick.sv
// Combinational rotating-priority picker: returns the first set bit of
// mask when scanning start, start+1, ... wrapping modulo N_OUT.
module rr_pick #(
  parameter int N_OUT = 2,
  parameter int SEL_W = $clog2(N_OUT)
) (
  input  logic [N_OUT-1:0] mask,
  input  logic [SEL_W-1:0] start,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  // Scan all channels once starting at the pointer; the first hit wins.
  always_comb begin
    int k;
    found = 1'b0;
    idx   = '0;
    k     = 0;
    for (int i = 0; i < N_OUT; i++) begin
      k = (int'(start) + i) % N_OUT;
      if (!found && mask[k]) begin
        found = 1'b1;
        idx   = SEL_W'(k);
      end
    end
  end

endmodule

// File: rtl/demux_dispatch_ctrl.sv
// 1-to-N_OUT dispatch controller with a single-entry holding register.
// Words are steered round-robin over the enable mask or to a fixed channel.
// Optional per-channel saturating fire counters: DEMUX_DISPATCH_CNT_EN.
module demux_dispatch_ctrl
  import demux_dispatch_pkg::*;
#(
  parameter int N_OUT  = 2,
  parameter int DATA_W = 8,
  parameter int SEL_W  = $clog2(N_OUT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              cfg_mode,
  input  logic [SEL_W-1:0]  cfg_sel,
  input  logic [N_OUT-1:0]  cfg_en,
  output logic [N_OUT-1:0]  out_valid,
  input  logic [N_OUT-1:0]  out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [SEL_W-1:0]  out_sel
`ifdef DEMUX_DISPATCH_CNT_EN
  ,
  output logic [N_OUT*CNT_W-1:0] dispatch_cnt
`endif
);

  state_e            state;
  logic              vld_p1;
  logic [DATA_W-1:0] hold_data_p1;
  logic [SEL_W-1:0]  hold_sel_p1;
  logic [SEL_W-1:0]  ptr;

  logic              rr_found;
  logic [SEL_W-1:0]  rr_idx;
  logic [N_OUT-1:0]  en_sh;
  logic [N_OUT-1:0]  ready_sh;
  logic              fixed_ok;
  logic              cand_found;
  logic [SEL_W-1:0]  cand_idx;
  logic              fire;
  logic              capture;

  // Pointer advance with explicit wrap at N_OUT-1 (N_OUT need not be a power of 2).
  function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] c);
    return (int'(c) == N_OUT - 1) ? '0 : c + 1'b1;
  endfunction

  rr_pick #(
    .N_OUT (N_OUT),
    .SEL_W (SEL_W)
  ) u_rr_pick (
    .mask  (cfg_en),
    .start (ptr),
    .found (rr_found),
    .idx   (rr_idx)
  );

  // Fixed-select candidate is valid only for an in-range, enabled channel.
  assign en_sh    = cfg_en >> cfg_sel;
  assign fixed_ok = (int'(cfg_sel) < N_OUT) && en_sh[0];

  // Candidate target for a word captured this cycle.
  always_comb begin
    cand_found = 1'b0;
    cand_idx   = '0;
    if (cfg_mode == MODE_FIXED) begin
      cand_found = fixed_ok;
      cand_idx   = cfg_sel;
    end else begin
      cand_found = rr_found;
      cand_idx   = rr_idx;
    end
  end

  // Only the latched target's ready matters; other channels are ignored.
  assign vld_p1   = (state == FULL);
  assign ready_sh = out_ready >> hold_sel_p1;
  assign fire     = vld_p1 && ready_sh[0];

  // Capture is allowed when empty or when the held word leaves this cycle.
  assign in_ready = !rst && cand_found && (state == EMPTY || fire);
  assign capture  = in_valid && in_ready;

  // One-hot valid toward the latched channel while a word is held.
  always_comb begin
    out_valid = '0;
    for (int k = 0; k < N_OUT; k++) begin
      out_valid[k] = vld_p1 && (hold_sel_p1 == SEL_W'(k));
    end
  end

  assign out_data = hold_data_p1;
  assign out_sel  = hold_sel_p1;

  // ---- stage p1: holding register, occupancy and round-robin pointer ----
  // Capture takes priority over drain so a same-cycle refill stays FULL.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= EMPTY;
      hold_data_p1 <= '0;
      hold_sel_p1  <= '0;
      ptr          <= '0;
    end else if (capture) begin
      state        <= FULL;
      hold_data_p1 <= in_data;
      hold_sel_p1  <= cand_idx;
      if (cfg_mode == MODE_RR) begin
        ptr <= next_ptr(cand_idx);
      end
    end else if (fire) begin
      state <= EMPTY;
    end
  end

`ifdef DEMUX_DISPATCH_CNT_EN
  logic [CNT_W-1:0] cnt [N_OUT];

  // Saturating increment; holds at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Count fires per channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_OUT; k++) begin
        cnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_OUT; k++) begin
        if (fire && (hold_sel_p1 == SEL_W'(k))) begin
          cnt[k] <= sat_inc(cnt[k]);
        end
      end
    end
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_cnt_out
    assign dispatch_cnt[g*CNT_W +: CNT_W] = cnt[g];
  end
`endif

endmodule

// File: doc/demux_dispatch_ctrl.md
Name: demux_dispatch_ctrl

Overview:
Controller that sequences a 1-to-N demultiplexer datapath. It accepts one valid/ready input stream, captures each word into a single-entry holding register, and steers it to exactly one of N_OUT output channels. The target channel is chosen by round-robin over an enable mask, or pinned by a fixed select. It sits between a single producer and N_OUT consumers that share the producer.

Parameters:
N_OUT, 2, number of output channels (>=2)
DATA_W, 8, data word width
SEL_W, $clog2(N_OUT), width of channel index (derived; never overridden)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
in_valid  in  1  producer word valid
in_ready  out  1  controller can capture this cycle
in_data  in  DATA_W  producer word
cfg_mode  in  1  0 = round-robin, 1 = fixed select
cfg_sel  in  SEL_W  fixed target channel (mode 1)
cfg_en  in  N_OUT  per-channel enable mask
out_valid  out  N_OUT  one-hot valid per channel
out_ready  in  N_OUT  per-channel consumer ready
out_data  out  DATA_W  shared data bus to all channels
out_sel  out  SEL_W  index of the channel currently targeted

Behaviour:
- Clocking: one clock, clk. Reset is rst, synchronous, active-high, sampled on the rising edge.
- Reset state:
  - state=EMPTY; hold_valid=0; out_valid=0; out_data=0; out_sel=0.
  - RR pointer ptr=0.
  - in_ready=0 while rst is high.
- States:
  - EMPTY: no word held.
  - FULL: word held and presented.
- Candidate target, evaluated combinationally on the capture cycle:
  - Mode 0: first index k scanning ptr, ptr+1, ... wrapping modulo N_OUT with cfg_en[k]=1.
  - Mode 1: cfg_sel, but only if cfg_sel<N_OUT and cfg_en[cfg_sel]=1.
  - If neither rule yields a target, no candidate exists.
- in_ready = !rst && candidate exists && (state==EMPTY || out fire this cycle). Refill in the same cycle as drain is allowed, giving 1 word/cycle throughput.
- Capture (in_valid && in_ready):
  - Latch in_data into out_data and the candidate into out_sel.
  - Go to FULL.
  - Mode 0 only: ptr <= (candidate+1) mod N_OUT. Mode 1 leaves ptr unchanged.
- FULL:
  - out_valid = one-hot(out_sel); all other bits 0.
  - out_data and out_sel stay stable until fire.
- Fire = out_valid[out_sel] && out_ready[out_sel]. On fire with no same-cycle capture, go to EMPTY and drive out_valid to 0 next cycle.
- Latency: capture at edge t makes out_valid high from cycle t+1. Minimum in-to-out latency is 1 cycle.
- Boundary conditions:
  - Changing cfg_* while FULL does not retarget the held word; it is delivered to the latched out_sel even if that channel is now disabled. New config applies from the next capture.
  - cfg_en all zero: in_ready=0 and no capture; the held word still drains.
  - ptr wraps N_OUT-1 -> 0.
  - out_ready on non-target channels is ignored.
  - rst during FULL drops the held word with no out_valid pulse, and returns to the reset state next cycle.
  - in_data is ignored when in_valid=0.

Optional Feature:
DEMUX_DISPATCH_CNT_EN
- Defined:
  - Adds output port dispatch_cnt, width N_OUT*16: one 16-bit counter per channel, channel k at bits [16k+15:16k].
  - Counter k increments on each fire to channel k and saturates at 16'hFFFF.
  - Counters are cleared by rst.
- Undefined: no port, no counters; all other behaviour identical.

Decomposition:
- Package demux_dispatch_pkg holds:
  - State enum {EMPTY, FULL}.
  - Mode constants MODE_RR=1'b0 and MODE_FIXED=1'b1.
  - Counter width constant CNT_W=16.
- One sub-module, rr_pick: combinational rotating priority picker.
  - Inputs: mask[N_OUT], start[SEL_W].
  - Outputs: found, idx[SEL_W].
  - Used for the mode 0 candidate.

Test Plan:
- N_OUT=2, mode 0, cfg_en=2'b11, out_ready=2'b11, in_valid held 1 with data 8'hA0..8'hA3 -> outputs go to ch0,1,0,1 in order, one word per cycle, out_valid first high 1 cycle after the first capture.
- N_OUT=4, mode 0, cfg_en=4'b1010, 4 words -> ch1,3,1,3; ptr wraps correctly.
- Mode 1, cfg_sel=1, out_ready[1]=0 for 3 cycles -> out_valid=2'b10 and out_data stable for all 3 cycles, in_ready=0; raise ready -> fire, next word captured in the same cycle.
- FULL targeting ch0 with out_ready=0, then cfg_en changed to 2'b10 -> word still delivered to ch0; next word goes to ch1.
- cfg_en=0 with in_valid=1 -> in_ready stays 0 for 5 cycles and no out_valid; assert rst while FULL -> out_valid=0 next cycle, ptr=0.
- With DEMUX_DISPATCH_CNT_EN: 3 fires to ch0 and 1 fire to ch1 -> dispatch_cnt = {16'd1, 16'd3}; counter preloaded near max saturates at 16'hFFFF.
